// File: rtl/regfile_issue_if.sv
// rtl/regfile_issue_if.sv - instruction issue and ALU handshake bundle for regfile_issue
interface regfile_issue_if #(
  parameter int WORD_SIZE = 16,
  parameter int AW        = 3
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_op;
  logic [AW-1:0]        in_rd;
  logic [AW-1:0]        in_rs1;
  logic [AW-1:0]        in_rs2;
  logic [WORD_SIZE-1:0] alu_a;
  logic [WORD_SIZE-1:0] alu_b;
  logic [3:0]           alu_op;
  logic [WORD_SIZE-1:0] alu_out;
  logic                 done;

  // register-file side
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, alu_out,
    output in_ready, alu_a, alu_b, alu_op, done
  );

  // issuer / ALU side
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, alu_out,
    input  in_ready, alu_a, alu_b, alu_op, done
  );
endinterface

// File: rtl/regfile_issue.sv
// rtl/regfile_issue.sv - serial register-file issue stage (IDLE/EXEC/WB); optional flags via REGFILE_ISSUE_FLAGS_EN
module regfile_issue #(
  parameter int  WORD_SIZE = 16,
  parameter int  REG_COUNT = 8,
  localparam int AW        = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_issue_if.slave       bus,
  input  logic [AW-1:0]        dbg_addr,
  output logic [WORD_SIZE-1:0] dbg_data
`ifdef REGFILE_ISSUE_FLAGS_EN
  ,
  output logic                 flag_z,
  output logic                 flag_n
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t               state_q, state_d;
  logic                 accept;
  logic                 wr_en;
  logic [WORD_SIZE-1:0] regs [REG_COUNT];
  logic [AW-1:0]        rd_q;
  logic [WORD_SIZE-1:0] alu_a_q;
  logic [WORD_SIZE-1:0] alu_b_q;
  logic [3:0]           alu_op_q;

  // state register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state, handshake and strobes
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    wr_en        = 1'b0;
    bus.in_ready = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = ~rst;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        wr_en   = 1'b1;
        state_d = WB;
      end
      WB: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // operand capture at accept (reads cannot race a write since execution is serial) and write-back at EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      rd_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else begin
      if (accept) begin
        rd_q     <= bus.in_rd;
        alu_a_q  <= regs[bus.in_rs1];
        alu_b_q  <= regs[bus.in_rs2];
        alu_op_q <= bus.in_op;
      end
      if (wr_en) regs[rd_q] <= bus.alu_out;
    end
  end

  assign bus.alu_a  = alu_a_q;
  assign bus.alu_b  = alu_b_q;
  assign bus.alu_op = alu_op_q;
  assign dbg_data   = regs[dbg_addr];

`ifdef REGFILE_ISSUE_FLAGS_EN
  // result flags follow the value written at the EXEC edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (wr_en) begin
      flag_z <= (bus.alu_out == '0);
      flag_n <= bus.alu_out[WORD_SIZE-1];
    end
  end
`endif

endmodule

// File: tb/tb_regfile_issue.sv
// tb/tb_regfile_issue.sv - directed bench for regfile_issue with a behavioural ALU
module tb_regfile_issue;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = 3;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SRA = 4'd3,
                         OP_SRL = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6, OP_XOR = 4'd7,
                         OP_EQ  = 4'd8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;
`ifdef REGFILE_ISSUE_FLAGS_EN
  logic          flag_z;
  logic          flag_n;
`endif

  int n_total = 0;
  int n_pass  = 0;

  regfile_issue_if #(.WORD_SIZE(W), .AW(AW)) bus ();

  regfile_issue #(.WORD_SIZE(W), .REG_COUNT(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
`ifdef REGFILE_ISSUE_FLAGS_EN
    ,
    .flag_z  (flag_z),
    .flag_n  (flag_n)
`endif
  );

  always #5 clk = ~clk;

  // behavioural ALU; undefined opcodes return zero
  always_comb begin
    case (bus.alu_op)
      OP_ADD:  bus.alu_out = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_out = bus.alu_a - bus.alu_b;
      OP_SLL:  bus.alu_out = bus.alu_a << bus.alu_b[3:0];
      OP_SRA:  bus.alu_out = $unsigned($signed(bus.alu_a) >>> bus.alu_b[3:0]);
      OP_SRL:  bus.alu_out = bus.alu_a >> bus.alu_b[3:0];
      OP_AND:  bus.alu_out = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_out = bus.alu_a | bus.alu_b;
      OP_XOR:  bus.alu_out = bus.alu_a ^ bus.alu_b;
      OP_EQ:   bus.alu_out = (bus.alu_a == bus.alu_b) ? 16'd1 : 16'd0;
      default: bus.alu_out = 16'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic reg_is(input string tag, input logic [AW-1:0] idx, input logic [W-1:0] exp);
    dbg_addr = idx;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic drive(input logic [3:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
  endtask

  // full instruction from a negedge in IDLE back to the negedge in the next IDLE
  task automatic issue(input logic [3:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    int k = 0;
    while (!bus.in_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) chk("issue_wait_ready", 0, 1);
    drive(op, rd, rs1, rs2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  int acc_cyc [3];
  int n_acc;
  int n_done;
  logic [3:0]    prog_op  [3];
  logic [AW-1:0] prog_rd  [3];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_rd    = '0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    dbg_addr     = '0;
    rst          = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_done", bus.done, 0);
    for (int i = 0; i < N; i++) reg_is("rst_reg", AW'(i), 16'h0000);
    @(negedge clk);

    // seed R6=1, R1=5, R2=3
    issue(OP_EQ, 3'd6, 3'd0, 3'd0);
    issue(OP_ADD, 3'd1, 3'd6, 3'd6);
    issue(OP_ADD, 3'd1, 3'd1, 3'd1);
    issue(OP_ADD, 3'd1, 3'd1, 3'd6);
    issue(OP_ADD, 3'd2, 3'd6, 3'd6);
    issue(OP_ADD, 3'd2, 3'd2, 3'd6);
    reg_is("seed_r1", 3'd1, 16'd5);
    reg_is("seed_r2", 3'd2, 16'd3);

    // SUB R3 = R1 - R2, observed cycle by cycle
    drive(OP_SUB, 3'd3, 3'd1, 3'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_rd = 3'd7; bus.in_rs1 = 3'd6; bus.in_op = OP_OR;
    chk("sub_exec_ready", bus.in_ready, 0);
    chk("sub_exec_done", bus.done, 0);
    chk("sub_alu_a", bus.alu_a, 16'd5);
    chk("sub_alu_b", bus.alu_b, 16'd3);
    chk("sub_alu_op", bus.alu_op, OP_SUB);
    reg_is("sub_r3_before", 3'd3, 16'd0);
    @(negedge clk);
    chk("sub_wb_ready", bus.in_ready, 0);
    chk("sub_wb_done", bus.done, 1);
    reg_is("sub_r3", 3'd3, 16'd2);
    @(negedge clk);
    chk("sub_idle_ready", bus.in_ready, 1);
    chk("sub_idle_done", bus.done, 0);
    chk("sub_alu_a_hold", bus.alu_a, 16'd5);
    reg_is("r7_untouched", 3'd7, 16'd0);

    // R7 = 15, R4 = 1 << 15, then R4 = R4 + R4 wraps to zero
    issue(OP_ADD, 3'd7, 3'd1, 3'd1);
    issue(OP_ADD, 3'd7, 3'd7, 3'd1);
    issue(OP_SLL, 3'd4, 3'd6, 3'd7);
    reg_is("sll_r4", 3'd4, 16'h8000);
`ifdef REGFILE_ISSUE_FLAGS_EN
    chk("sll_flag_z", flag_z, 0);
    chk("sll_flag_n", flag_n, 1);
`endif
    issue(OP_ADD, 3'd4, 3'd4, 3'd4);
    reg_is("wrap_r4", 3'd4, 16'h0000);
`ifdef REGFILE_ISSUE_FLAGS_EN
    chk("wrap_flag_z", flag_z, 1);
    chk("wrap_flag_n", flag_n, 0);
`endif

    // back-to-back: in_valid held high across three instructions
    prog_op[0] = OP_OR;  prog_rd[0] = 3'd0;
    prog_op[1] = OP_AND; prog_rd[1] = 3'd3;
    prog_op[2] = OP_XOR; prog_rd[2] = 3'd7;
    acc_cyc = '{0, 0, 0};
    n_acc  = 0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.done) n_done++;
      if (bus.in_ready && n_acc < 3) begin
        drive(prog_op[n_acc], prog_rd[n_acc], 3'd1, 3'd2);
        acc_cyc[n_acc] = i;
        n_acc++;
      end else begin
        bus.in_valid = (n_acc < 3);
        bus.in_rd    = 3'($urandom_range(0, 7));
        bus.in_rs1   = 3'($urandom_range(0, 7));
        bus.in_op    = 4'($urandom_range(0, 15));
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_accepts", n_acc, 3);
    chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], 3);
    chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], 3);
    chk("b2b_dones", n_done, 3);
    reg_is("b2b_or_r0", 3'd0, 16'd7);
    reg_is("b2b_and_r3", 3'd3, 16'd1);
    reg_is("b2b_xor_r7", 3'd7, 16'd6);
    @(negedge clk);

    // reset while XOR R5 is in EXEC
    drive(OP_XOR, 3'd5, 3'd1, 3'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("abort_exec_op", bus.alu_op, OP_XOR);
    rst = 1'b1;
    #1;
    chk("abort_rst_ready", bus.in_ready, 0);
    chk("abort_rst_done", bus.done, 0);
    chk("abort_rst_alu_a", bus.alu_a, 0);
`ifdef REGFILE_ISSUE_FLAGS_EN
    chk("abort_rst_flag_z", flag_z, 0);
`endif
    @(negedge clk);
    chk("abort_rst_done2", bus.done, 0);
    rst = 1'b0;
    #1;
    chk("abort_idle_ready", bus.in_ready, 1);
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    reg_is("abort_r5", 3'd5, 16'd0);
    reg_is("abort_r1_cleared", 3'd1, 16'd0);

    // undefined opcode 12 is forwarded and its zero result written
    issue(OP_EQ, 3'd2, 3'd0, 3'd0);
    reg_is("op12_seed_r2", 3'd2, 16'd1);
    drive(4'd12, 3'd2, 3'd2, 3'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("op12_alu_op", bus.alu_op, 4'd12);
    chk("op12_alu_a", bus.alu_a, 16'd1);
    @(negedge clk);
    chk("op12_done", bus.done, 1);
    reg_is("op12_r2", 3'd2, 16'd0);
    @(negedge clk);
    chk("op12_idle_ready", bus.in_ready, 1);
    chk("op12_idle_done", bus.done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/regfile_issue.md
REGFILE_ISSUE -- requirements
Module: regfile_issue

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, giving the datapath width in bits.
REQ-002 The block SHALL have parameter REG_COUNT, default 8, giving the number of general registers; REG_COUNT SHALL be a power of two.
REQ-003 AW = log2(REG_COUNT) SHALL be the register address width, derived internally.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, width 1: instruction offered.
REQ-007 The block SHALL have port in_ready, output, width 1: the block accepts an instruction this cycle.
REQ-008 The block SHALL have port in_op, input, width 4: ALU opcode in enum order ADD=0, SUB=1, LEFT_SHIFT=2, RIGHT_SHIFT_ARITHMETIC=3, RIGHT_SHIFT_LOGIC=4, AND=5, OR=6, XOR=7, EQUAL=8.
REQ-009 The block SHALL have ports in_rd, in_rs1 and in_rs2, input, width AW each: destination, source A and source B register indices.
REQ-010 The block SHALL have ports alu_a and alu_b, output, width WORD_SIZE each: operands driven to the ALU.
REQ-011 The block SHALL have port alu_op, output, width 4: opcode driven to the ALU.
REQ-012 The block SHALL have port alu_out, input, width WORD_SIZE: combinational result returned by the ALU.
REQ-013 The block SHALL have port done, output, width 1: one-cycle pulse marking write-back complete.
REQ-014 The block SHALL have port dbg_addr, input, width AW: debug read index.
REQ-015 The block SHALL have port dbg_data, output, width WORD_SIZE: combinational value of R[dbg_addr].
REQ-016 The block SHALL have port flag_z, output, width 1: last result was zero (FLAGS_EN builds only).
REQ-017 The block SHALL have port flag_n, output, width 1: MSB of last result (FLAGS_EN builds only).

Function
REQ-018 The block SHALL implement an FSM with states IDLE, EXEC and WB; the encoding is free.
REQ-019 In IDLE, in_ready SHALL be 1; in EXEC and WB, in_ready SHALL be 0.
REQ-020 On an edge in IDLE with in_valid=1, the block SHALL latch in_op, in_rd, in_rs1 and in_rs2 and move to EXEC; with in_valid=0 it SHALL remain in IDLE.
REQ-021 In EXEC, the block SHALL drive alu_a=R[rs1], alu_b=R[rs2] and alu_op=latched op, all from registers; at the EXEC edge it SHALL write alu_out into R[rd] and move to WB.
REQ-022 In IDLE and WB, alu_a, alu_b and alu_op SHALL hold their last values; after reset they SHALL be 0.
REQ-023 In WB, done SHALL be 1 for exactly that cycle, then the FSM SHALL return to IDLE; done SHALL be 0 in every other state.
REQ-024 Latency SHALL be 2 edges from acceptance to register write, and done SHALL appear in the cycle after the write; throughput SHALL be 1 instruction per 3 cycles.
REQ-025 When rs1, rs2 and rd are equal, the old value SHALL be read and the result overwrite it; there SHALL be no bypass and no hazard, because execution is serial.
REQ-026 Opcodes 9..15 SHALL be forwarded unchanged, and whatever alu_out returns SHALL be written.
REQ-027 in_* changes outside the IDLE accept edge SHALL have no effect.
REQ-028 dbg_data SHALL reflect a write in the cycle after the write edge.
REQ-029 All REG_COUNT registers SHALL be writable, including R0.

Reset
REQ-030 rst=1 SHALL immediately force the FSM to IDLE, every R[i] to 0, the alu_* outputs to 0, done to 0, and flags to 0.
REQ-031 in_ready SHALL be 0 while rst=1.
REQ-032 Reset during EXEC SHALL abort the instruction: no write, and no done pulse.

Configuration
REQ-033 With macro REGFILE_ISSUE_FLAGS_EN defined, flag_z and flag_n SHALL exist and update on the EXEC edge, with flag_z=(alu_out==0) and flag_n=alu_out[WORD_SIZE-1], holding otherwise.
REQ-034 With REGFILE_ISSUE_FLAGS_EN undefined, flag_z and flag_n SHALL not exist and no flag logic SHALL be built.

Verification
REQ-035 The bench SHALL apply rst, release it, and read all dbg_addr -> every dbg_data=0, in_ready=1, done=0.
REQ-036 With an ALU model, the bench SHALL seed R1=5 and R2=3 via ADD chains, then issue SUB rd=3 rs1=1 rs2=2 -> alu_a=5 and alu_b=3 in EXEC, R3=2, done one cycle later, in_ready low for 2 cycles.
REQ-037 The bench SHALL issue ADD rd=4 rs1=4 rs2=4 with R4=0x8000 -> R4=0x0000; with FLAGS_EN, flag_z=1 and flag_n=0.
REQ-038 The bench SHALL hold in_valid=1 continuously with 3 distinct instructions -> exactly 3 accepts spaced 3 cycles apart and 3 done pulses.
REQ-039 The bench SHALL assert rst during EXEC of XOR rd=5 -> R5 stays 0, no done pulse, IDLE after release.
REQ-040 The bench SHALL issue in_op=12 with the ALU model returning 0 -> R[rd]=0x0000, done pulses, and the FSM returns to IDLE.
